// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM state type, reset PC
// and a word-alignment helper used by the fetch stage.
package cpu_defs_pkg;

    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FETCH       = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_HALT        = 2'd3
    } fetch_state_t;

    // Forces an address onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ext_sel_decode.sv
// Opcode to extender-select decode: 1 selects sign extension, 0 zero extension.
module ext_sel_decode
    import cpu_defs_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       ext_sel
);

    // Arithmetic, compare, memory and branch immediates are signed.
    always_comb begin
        ext_sel = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE: ext_sel = 1'b1;
            default:                      ext_sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_issue_stage.sv
// Fetch stage: owns the PC, fetches over a req/rvalid handshake and holds one
// instruction for decode. Define FETCH_TRACE_EN to print each captured word.
module fetch_issue_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] immediate,
    output logic        ext_sel,
    output logic        halted
);

    fetch_state_t state_r, state_s;
    logic [31:0]  pc_r, id_pc_r, id_instr_r;
    logic         halt_pending_r, imem_req_r, id_valid_r, halted_r;
    logic         capture_s, redirect_s;

    // Next-state logic; a redirect overrides everything except the halted state.
    always_comb begin
        state_s    = state_r;
        capture_s  = 1'b0;
        redirect_s = 1'b0;
        case (state_r)
            ST_IDLE: state_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_rvalid) begin
                    capture_s = 1'b1;
                    state_s   = ST_WAIT_ACCEPT;
                end else begin
                    state_s   = ST_FETCH;
                end
            end
            ST_WAIT_ACCEPT: begin
                if (id_ready) begin
                    state_s = halt_pending_r ? ST_HALT : ST_FETCH;
                end else begin
                    state_s = ST_WAIT_ACCEPT;
                end
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_IDLE;
        endcase
        if (redirect_valid && (state_r != ST_HALT)) begin
            redirect_s = 1'b1;
            capture_s  = 1'b0;
            state_s    = ST_FETCH;
        end else begin
            redirect_s = 1'b0;
        end
    end

    // State, PC, output register and registered handshake outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r        <= ST_IDLE;
            pc_r           <= word_align(RESET_PC);
            id_pc_r        <= 32'h0000_0000;
            id_instr_r     <= 32'h0000_0000;
            halt_pending_r <= 1'b0;
            imem_req_r     <= 1'b0;
            id_valid_r     <= 1'b0;
            halted_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            imem_req_r <= (state_s == ST_FETCH);
            id_valid_r <= (state_s == ST_WAIT_ACCEPT);
            halted_r   <= (state_s == ST_HALT);
            if (redirect_s) begin
                pc_r           <= word_align(redirect_pc);
                halt_pending_r <= 1'b0;
            end else if (capture_s) begin
                id_instr_r     <= imem_rdata;
                id_pc_r        <= pc_r;
                pc_r           <= pc_r + PC_STEP;
                halt_pending_r <= (imem_rdata[31:26] == OP_HALT);
            end
        end
    end

`ifdef FETCH_TRACE_EN
    logic trace_pending_r;

    // Report a capture one cycle later, once the output register holds it.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            trace_pending_r <= 1'b0;
        end else begin
            trace_pending_r <= capture_s;
            if (trace_pending_r) begin
                $display("[fetch] pc=%08h instr=%08h ext_sel=%0b", id_pc_r, id_instr_r, ext_sel);
            end
        end
    end
`endif

    ext_sel_decode u_ext_sel_decode (
        .opcode  (id_instr_r[31:26]),
        .ext_sel (ext_sel)
    );

    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r;
    assign id_valid  = id_valid_r;
    assign id_pc     = id_pc_r;
    assign id_instr  = id_instr_r;
    assign halted    = halted_r;
    assign opcode    = id_instr_r[31:26];
    assign rs        = id_instr_r[25:21];
    assign rt        = id_instr_r[20:16];
    assign rd        = id_instr_r[15:11];
    assign immediate = id_instr_r[15:0];

endmodule

// File: tb/tb_fetch_issue_stage.sv
// Self-checking bench for fetch_issue_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_fetch_issue_stage;
    import cpu_defs_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc, id_instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] immediate;
    logic        ext_sel, halted;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: what the stage should be doing in spec terms.
    bit          m_started, m_valid, m_hp, m_halted;
    logic [31:0] m_pc, m_idpc, m_instr;

    logic [5:0] sext_ops [0:6] = '{6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [5:0] ops_tbl  [0:10] = '{6'h08, 6'h09, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05,
                                    6'h0C, 6'h0D, 6'h0E, 6'h00};

    always #5 CLK = ~CLK;

    fetch_issue_stage dut (
        .CLK(CLK), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .immediate(immediate),
        .ext_sel(ext_sel), .halted(halted)
    );

    function automatic bit ref_ext_sel(input logic [5:0] op);
        for (int i = 0; i < 7; i++) if (sext_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_started = 0; m_valid = 0; m_hp = 0; m_halted = 0;
        m_pc = 32'h0; m_idpc = 32'h0; m_instr = 32'h0;
    endtask

    // Drive one cycle of inputs, advance the model, end at the next negedge.
    task automatic step(input logic rv, input logic [31:0] rdat, input logic rdy,
                        input logic redir, input logic [31:0] rpc);
        imem_rvalid = rv; imem_rdata = rdat; id_ready = rdy;
        redirect_valid = redir; redirect_pc = rpc;
        if (m_halted) begin
        end else if (redir) begin
            m_pc = rpc & 32'hFFFF_FFFC; m_valid = 0; m_hp = 0; m_started = 1;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_valid) begin
            if (rdy) begin m_valid = 0; if (m_hp) m_halted = 1; end
        end else if (rv) begin
            m_instr = rdat; m_idpc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1;
            m_hp = (rdat[31:26] == 6'h3F);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #1 Reset = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        tests_run++; if ({id_pc, id_instr} !== 64'h0) begin tests_failed++; $display("FAIL reset_idreg: got %h/%h want 0/0", id_pc, id_instr); end
        tests_run++; if ({opcode, rs, rt, rd, immediate, ext_sel, halted} !== 44'h0) begin tests_failed++; $display("FAIL reset_fields: got %h want 0", {opcode, rs, rt, rd, immediate, ext_sel, halted}); end
        Reset = 1'b1;
    endtask

    task automatic test_first_fetch();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL idle_req: got %b want 0", imem_req); end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tests_run++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL fetch0_req_addr: got %b/%h want 1/0", imem_req, imem_addr); end
        step(1'b1, 32'h2008_FFFF, 1'b0, 1'b0, 32'h0);
        tests_run++; if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL addi_valid_pc: got %b/%h want 1/0", id_valid, id_pc); end
        tests_run++; if ({immediate, ext_sel} !== {16'hFFFF, 1'b1}) begin tests_failed++; $display("FAIL addi_imm_ext: got %h/%b want ffff/1", immediate, ext_sel); end
        tests_run++; if ({imem_req, imem_addr} !== {1'b0, 32'h4}) begin tests_failed++; $display("FAIL addi_next_addr: got %b/%h want 0/4", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h3408_8000, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            tests_run++;
            if ({id_valid, imem_req, id_pc, id_instr, ext_sel, opcode, immediate} !==
                {1'b1, 1'b0, 32'h4, 32'h3408_8000, 1'b0, 6'h0D, 16'h8000}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got v=%b req=%b pc=%h ins=%h ext=%b want 1/0/4/34088000/0", i, id_valid, imem_req, id_pc, id_instr, ext_sel);
            end
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tests_run++; if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin tests_failed++; $display("FAIL stall_accept: got %b/%b/%h want 0/1/8", id_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drop();
        step(1'b1, 32'h2009_1234, 1'b0, 1'b1, 32'h0000_0103);
        tests_run++; if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin tests_failed++; $display("FAIL redirect_addr: got %b/%b/%h want 0/1/100", id_valid, imem_req, imem_addr); end
        tests_run++; if ({id_pc, id_instr} !== {32'h4, 32'h3408_8000}) begin tests_failed++; $display("FAIL redirect_nocapture: got %h/%h want 4/34088000", id_pc, id_instr); end
    endtask

    task automatic test_wrap();
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        tests_run++; if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_start: got %h want fffffffc", imem_addr); end
        step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0);
        tests_run++; if ({id_pc, imem_addr, ext_sel} !== {32'hFFFF_FFFC, 32'h0, 1'b0}) begin tests_failed++; $display("FAIL wrap_next: got %h/%h/%b want fffffffc/0/0", id_pc, imem_addr, ext_sel); end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_halt();
        step(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'h0);
        tests_run++; if ({id_valid, id_pc, opcode} !== {1'b1, 32'h0, 6'h3F}) begin tests_failed++; $display("FAIL halt_capture: got %b/%h/%h want 1/0/3f", id_valid, id_pc, opcode); end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tests_run++; if ({halted, imem_req, id_valid} !== 3'b100) begin tests_failed++; $display("FAIL halt_enter: got %b%b%b want 100", halted, imem_req, id_valid); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, 1'b1, 1'b1, 32'h0000_0200);
            tests_run++; if ({halted, imem_req, imem_addr} !== {1'b1, 1'b0, 32'h4}) begin tests_failed++; $display("FAIL halt_ignore_redirect[%0d]: got %b/%b/%h want 1/0/4", i, halted, imem_req, imem_addr); end
        end
        #2 Reset = 1'b0;
        model_reset();
        #1;
        tests_run++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b0, 32'h0}) begin tests_failed++; $display("FAIL halt_reset: got %b/%b/%h want 0/0/0", halted, imem_req, imem_addr); end
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic test_async_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_req: got %b want 1", imem_req); end
        #2 Reset = 1'b0;
        model_reset();
        #1;
        tests_run++; if ({imem_req, id_valid} !== 2'b00) begin tests_failed++; $display("FAIL areset_fetch: got %b%b want 00", imem_req, id_valid); end
        @(negedge CLK);
        Reset = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h8C00_0004, 1'b0, 1'b0, 32'h0);
        tests_run++; if ({id_valid, ext_sel} !== 2'b11) begin tests_failed++; $display("FAIL areset_lw_hold: got %b%b want 11", id_valid, ext_sel); end
        #2 Reset = 1'b0;
        model_reset();
        #1;
        tests_run++; if ({id_valid, id_instr, ext_sel} !== 34'h0) begin tests_failed++; $display("FAIL areset_wait: got %b/%h/%b want 0/0/0", id_valid, id_instr, ext_sel); end
        @(negedge CLK);
        Reset = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] word;
        int          sel;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tests_run++;
            if ({imem_req, imem_addr, id_valid, id_pc, id_instr, halted} !==
                {(m_started && !m_valid && !m_halted), m_pc, m_valid, m_idpc, m_instr, m_halted}) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: got req=%b addr=%h v=%b pc=%h ins=%h h=%b want req=%b addr=%h v=%b pc=%h ins=%h h=%b",
                         cyc, imem_req, imem_addr, id_valid, id_pc, id_instr, halted,
                         (m_started && !m_valid && !m_halted), m_pc, m_valid, m_idpc, m_instr, m_halted);
            end
            tests_run++;
            if ({opcode, rs, rt, rd, immediate, ext_sel} !==
                {m_instr[31:26], m_instr[25:21], m_instr[20:16], m_instr[15:11], m_instr[15:0], ref_ext_sel(m_instr[31:26])}) begin
                tests_failed++;
                $display("FAIL rand_fields[%0d]: got %h/%b want %h/%b", cyc, {opcode, rs, rt, rd, immediate}, ext_sel,
                         {m_instr[31:26], m_instr[25:21], m_instr[20:16], m_instr[15:11], m_instr[15:0]}, ref_ext_sel(m_instr[31:26]));
            end
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                Reset = 1'b0;
                model_reset();
                @(negedge CLK);
                Reset = 1'b1;
            end else begin
                sel = $urandom_range(0, 31);
                if (sel < 11) op = ops_tbl[sel];
                else if (sel < 31) op = 6'($urandom);
                else op = 6'h3F;
                word = {op, 26'($urandom)};
                step(1'($urandom), word, 1'($urandom), ($urandom_range(0, 7) == 0), $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_drop();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
